// File: rtl/conv_store_unit_if.sv
// Bus bundle between the conv store unit and its neighbours.
// Groups two links:
//   - output-buffer read port: obuf_rd_en / obuf_rd_addr out, obuf_rd_data back
//     (data valid exactly one cycle after obuf_rd_en).
//   - memory write port: wr_valid / wr_addr / wr_data / wr_last out, wr_ready back.
// master = the store unit, slave = the buffer/memory side.
interface conv_store_unit_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int OBUF_AW = 12
);
  logic               obuf_rd_en;
  logic [OBUF_AW-1:0] obuf_rd_addr;
  logic [DATA_W-1:0]  obuf_rd_data;

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_last;

  modport master (
    output obuf_rd_en, obuf_rd_addr, wr_valid, wr_addr, wr_data, wr_last,
    input  obuf_rd_data, wr_ready
  );

  modport slave (
    input  obuf_rd_en, obuf_rd_addr, wr_valid, wr_addr, wr_data, wr_last,
    output obuf_rd_data, wr_ready
  );
endinterface

// File: rtl/conv_store_unit.sv
// conv_store_unit: store stage behind the conv controller.
// Each one-cycle conv_store request drains words_per_chunk words from the
// output buffer (addresses 0..words-1) and streams them as valid/ready write
// beats at consecutive byte addresses, then pulses conv_store_fin.
// A running write pointer carries on across chunks; conv_start reloads it
// from base_addr (only while not streaming).
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   conv_start          layer start, reloads the write pointer
//   conv_store          one-cycle chunk request (ignored unless idle)
//   base_addr           layer byte base address
//   words_per_chunk     beats in this chunk (0 = finish immediately)
//   conv_store_fin      one-cycle pulse once the whole chunk is accepted
//   busy                high whenever not idle
//   bus                 output-buffer read port + memory write port (master)
module conv_store_unit #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int OBUF_AW = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                conv_start,
  input  logic                conv_store,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         words_per_chunk,
  output logic                conv_store_fin,
  output logic                busy,
  conv_store_unit_if.master   bus
);

  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [15:0]        r_words;
  logic [15:0]        r_rd_cnt;
  logic [15:0]        r_beat_cnt;
  logic [DATA_W-1:0]  r_fifo [2];
  logic [1:0]         r_fifo_cnt;
  logic               r_wr_sel;
  logic               r_rd_sel;
  logic               r_rd_pend;   // read issued last cycle, data arriving now

  logic w_credit;
  logic w_rd_issue;
  logic w_fifo_ne;
  logic w_pop;
  logic w_last;

  // Two skid slots shared between queued words and the read still in flight,
  // so a read is only issued when it is guaranteed a slot on return.
  assign w_credit   = ({1'b0, r_fifo_cnt} + {2'b00, r_rd_pend}) < 3'd2;
  assign w_rd_issue = (r_state == S_RUN) && (r_rd_cnt < r_words) && w_credit;
  assign w_fifo_ne  = (r_fifo_cnt != 2'd0);
  assign w_pop      = w_fifo_ne && bus.wr_ready;
  assign w_last     = (r_beat_cnt == r_words - 16'd1);

  assign bus.obuf_rd_en   = w_rd_issue;
  assign bus.obuf_rd_addr = r_rd_cnt[OBUF_AW-1:0];
  assign bus.wr_valid     = w_fifo_ne;
  assign bus.wr_addr      = r_wr_ptr;
  assign bus.wr_data      = r_fifo[r_rd_sel];
  assign bus.wr_last      = w_fifo_ne && w_last;

  assign conv_store_fin = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

  // NOTE: every register here, including state, uses non-blocking assignment so
  // all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_words    <= '0;
      r_rd_cnt   <= '0;
      r_beat_cnt <= '0;
      // NOTE: the skid slots are reset (unlike a real RAM) because wr_data is
      // driven straight from the head slot and must read 0 out of reset.
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_fifo_cnt <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_pend  <= 1'b0;
    end else begin
      // Read return lands in the FIFO the cycle after the read was issued.
      if (r_rd_pend) begin
        r_fifo[r_wr_sel] <= bus.obuf_rd_data;
        r_wr_sel         <= ~r_wr_sel;
      end
      if (w_pop) begin
        r_rd_sel   <= ~r_rd_sel;
        r_wr_ptr   <= r_wr_ptr + BEAT_BYTES;
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};

      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end

      // The FIFO is always empty outside RUN, so the pointer reloads below
      // never collide with a beat advancing it.
      unique case (r_state)
        S_IDLE: begin
          if (conv_start) begin
            r_wr_ptr <= base_addr;
          end
          if (conv_store) begin
            r_words    <= words_per_chunk;
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
            r_state    <= (words_per_chunk == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop && w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (conv_start) begin
            r_wr_ptr <= base_addr;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_store_unit.sv
// Directed bench for conv_store_unit. A beat-level reference (queue of expected
// beats per accepted chunk, per-chunk pointer arithmetic) is compared with the
// DUT every cycle, plus literal expectations taken from hand-worked sequences.
module tb_conv_store_unit;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 32;
  localparam int OBUF_AW = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        conv_start;
  logic        conv_store;
  logic [31:0] base_addr;
  logic [15:0] words_per_chunk;
  logic        conv_store_fin;
  logic        busy;

  conv_store_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OBUF_AW(OBUF_AW)) bus ();

  conv_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OBUF_AW(OBUF_AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .conv_start      (conv_start),
    .conv_store      (conv_store),
    .base_addr       (base_addr),
    .words_per_chunk (words_per_chunk),
    .conv_store_fin  (conv_store_fin),
    .busy            (busy),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output-buffer model: word at address a of the current chunk is {salt, a}.
  logic [31:0] salt = 32'd0;
  always @(posedge clk) begin
    if (bus.obuf_rd_en) bus.obuf_rd_data <= {salt, 20'd0, bus.obuf_rd_addr};
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

  beat_t       exp_q[$];
  mstate_t     m_state = M_IDLE;
  logic [31:0] m_ptr = 32'd0;
  int          m_store_cyc = 0;
  bit          m_first_seen = 1'b1;
  int          m_issued = 0;
  int          m_accepted = 0;
  int          m_words = 0;

  logic [31:0] hs_addr[$];
  logic [63:0] hs_data[$];
  int          hs_cyc[$];
  int          fin_cyc[$];
  int          store_cyc[$];
  int          first_lat[$];
  int          busy_cycles = 0;

  bit          p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [31:0] p_addr = '0;
  logic [63:0] p_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_rd_en",    bus.obuf_rd_en, 0);
      check("rst_rd_addr",  bus.obuf_rd_addr, 0);
      check("rst_wr_valid", bus.wr_valid, 0);
      check("rst_wr_addr",  bus.wr_addr, 0);
      check("rst_wr_data",  bus.wr_data, 0);
      check("rst_wr_last",  bus.wr_last, 0);
      check("rst_fin",      conv_store_fin, 0);
      check("rst_busy",     busy, 0);
      exp_q.delete();
      m_state = M_IDLE;
      m_ptr = 32'd0;
      m_issued = 0;
      m_accepted = 0;
      m_first_seen = 1'b1;
      p_valid = 1'b0;
    end else begin
      bit hs, hs_last;
      check("fin",  conv_store_fin, m_state == M_DONE);
      check("busy", busy, m_state != M_IDLE);
      if (busy) busy_cycles++;
      if (conv_store_fin) fin_cyc.push_back(cyc);
      if (m_state == M_IDLE) check("idle_wr_addr", bus.wr_addr, m_ptr);
      if (m_state != M_RUN) begin
        check("valid_outside_run", bus.wr_valid, 0);
        check("rd_en_outside_run", bus.obuf_rd_en, 0);
      end else begin
        if (bus.wr_valid) begin
          if (exp_q.size() == 0) check("valid_no_beat_left", bus.wr_valid, 0);
          else begin
            check("wr_addr", bus.wr_addr, exp_q[0].addr);
            check("wr_data", bus.wr_data, exp_q[0].data);
            check("wr_last", bus.wr_last, exp_q[0].last);
          end
          if (!m_first_seen) begin
            m_first_seen = 1'b1;
            first_lat.push_back(cyc - m_store_cyc);
            check("first_valid_latency", cyc - m_store_cyc, 3);
          end
        end
        if (bus.obuf_rd_en) begin
          check("rd_addr", bus.obuf_rd_addr, m_issued);
          check("rd_within_chunk", m_issued < m_words, 1);
          check("rd_credit", (m_issued - m_accepted) < 2, 1);
        end
      end
      // Outputs must hold while a beat is stalled.
      if (p_valid && !p_ready) begin
        check("stall_valid", bus.wr_valid, 1);
        check("stall_addr",  bus.wr_addr, p_addr);
        check("stall_data",  bus.wr_data, p_data);
        check("stall_last",  bus.wr_last, p_last);
      end
      p_valid = bus.wr_valid; p_ready = bus.wr_ready;
      p_addr = bus.wr_addr; p_data = bus.wr_data; p_last = bus.wr_last;

      // Advance the model to the next edge.
      hs = bus.wr_valid && bus.wr_ready;
      hs_last = 1'b0;
      if (m_state == M_RUN && hs && exp_q.size() > 0) begin
        hs_addr.push_back(bus.wr_addr);
        hs_data.push_back(bus.wr_data);
        hs_cyc.push_back(cyc);
        hs_last = exp_q[0].last;
        void'(exp_q.pop_front());
        m_accepted++;
      end
      if (m_state == M_RUN && bus.obuf_rd_en) m_issued++;
      case (m_state)
        M_IDLE: begin
          if (conv_start) m_ptr = base_addr;
          if (conv_store) begin
            m_words = int'(words_per_chunk);
            for (int i = 0; i < m_words; i++) begin
              beat_t b;
              b.addr = m_ptr + 32'(8 * i);
              b.data = {salt, 32'(i)};
              b.last = (i == m_words - 1);
              exp_q.push_back(b);
            end
            m_ptr = m_ptr + 32'(8 * m_words);
            m_store_cyc = cyc;
            store_cyc.push_back(cyc);
            m_first_seen = (m_words == 0);
            m_issued = 0;
            m_accepted = 0;
            m_state = (m_words == 0) ? M_DONE : M_RUN;
          end
        end
        M_RUN:  if (hs_last) m_state = M_DONE;
        M_DONE: begin
          if (conv_start) m_ptr = base_addr;
          m_state = M_IDLE;
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  bit ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit start, input bit store, input logic [31:0] base,
                       input logic [15:0] words);
    conv_start = start;
    conv_store = store;
    base_addr = base;
    words_per_chunk = words;
    tick();
    conv_start = 1'b0;
    conv_store = 1'b0;
  endtask

  task automatic wait_fin(input int budget, input bit bp);
    int  n0 = fin_cyc.size();
    bit  got = 1'b0;
    int  k = 0;
    while (!got && k < budget) begin
      if (bp) bus.wr_ready = ready_pat[k % 6];
      tick();
      k++;
      if (fin_cyc.size() > n0) got = 1'b1;
    end
    bus.wr_ready = 1'b1;
    check("fin_within_budget", got, 1);
  endtask

  initial begin
    int n_fin0, n_busy0, n_hs0, k;
    reset = 1'b0;
    conv_start = 1'b0;
    conv_store = 1'b0;
    base_addr = '0;
    words_per_chunk = '0;
    bus.wr_ready = 1'b1;
    bus.obuf_rd_data = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 1: base 0x1000, four beats.
    salt = 32'd1;
    drive(1'b1, 1'b0, 32'h1000, 16'd0);
    drive(1'b0, 1'b1, 32'h0, 16'd4);
    wait_fin(50, 1'b0);
    check("t1_addr0", hs_addr[0], 64'h1000);
    check("t1_addr3", hs_addr[3], 64'h1018);
    check("t1_data2", hs_data[2], {32'd1, 32'd2});
    check("t1_first_lat", first_lat[0], 3);
    check("t1_fin_after_last", fin_cyc[0] - hs_cyc[3], 1);
    tick();

    // 2: continue without reload, three beats.
    salt = 32'd2;
    drive(1'b0, 1'b1, 32'h0, 16'd3);
    wait_fin(50, 1'b0);
    check("t2_addr0", hs_addr[4], 64'h1020);
    check("t2_addr2", hs_addr[6], 64'h1030);
    check("t2_data0", hs_data[4], {32'd2, 32'd0});
    tick();

    // 3: five beats under backpressure.
    salt = 32'd3;
    drive(1'b0, 1'b1, 32'h0, 16'd5);
    wait_fin(100, 1'b1);
    check("t3_beats", hs_addr.size(), 12);
    check("t3_addr0", hs_addr[7], 64'h1038);
    check("t3_addr4", hs_addr[11], 64'h1058);
    check("t3_data2", hs_data[9], {32'd3, 32'd2});
    check("t3_data4", hs_data[11], {32'd3, 32'd4});
    tick();

    // 4: empty chunk.
    n_busy0 = busy_cycles;
    n_hs0 = hs_addr.size();
    drive(1'b0, 1'b1, 32'h0, 16'd0);
    wait_fin(10, 1'b0);
    tick();
    check("t4_fin_lat", fin_cyc[fin_cyc.size()-1] - store_cyc[store_cyc.size()-1], 1);
    check("t4_busy_cycles", busy_cycles - n_busy0, 1);
    check("t4_no_beats", hs_addr.size(), n_hs0);

    // 5: extra conv_store and conv_start while running are ignored.
    salt = 32'd4;
    n_fin0 = fin_cyc.size();
    drive(1'b0, 1'b1, 32'h0, 16'd4);
    tick();
    drive(1'b1, 1'b1, 32'h9000, 16'd7);
    wait_fin(50, 1'b0);
    repeat (8) tick();
    check("t5_one_fin", fin_cyc.size() - n_fin0, 1);
    check("t5_addr0", hs_addr[12], 64'h1060);
    check("t5_addr3", hs_addr[15], 64'h1078);
    check("t5_ptr_after", bus.wr_addr, 64'h1080);

    // 6: reset in the middle of a six-beat chunk.
    salt = 32'd5;
    n_fin0 = fin_cyc.size();
    n_hs0 = hs_addr.size();
    drive(1'b0, 1'b1, 32'h0, 16'd6);
    k = 0;
    while (hs_addr.size() < n_hs0 + 2 && k < 50) begin
      tick();
      k++;
    end
    check("t6_two_beats", hs_addr.size() >= n_hs0 + 2, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", bus.wr_valid, 0);
    check("t6_async_addr",  bus.wr_addr, 0);
    check("t6_async_data",  bus.wr_data, 0);
    check("t6_async_rd_en", bus.obuf_rd_en, 0);
    check("t6_async_busy",  busy, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_no_fin", fin_cyc.size(), n_fin0);
    salt = 32'd6;
    n_hs0 = hs_addr.size();
    drive(1'b1, 1'b1, 32'h2000, 16'd2);
    wait_fin(50, 1'b0);
    check("t6_addr0", hs_addr[n_hs0], 64'h2000);
    check("t6_addr1", hs_addr[n_hs0+1], 64'h2008);
    check("t6_data1", hs_data[n_hs0+1], {32'd6, 32'd1});
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
